// File: rtl/ham_encoder_tx_if.sv
// Bus bundle for the Hamming(7,4) serial transmitter.
//
// Handshake: a nibble transfers on a rising clock edge where data_valid and
// data_ready are both 1. The upstream side may raise data_valid at any time.
// data_ready is a registered output and never depends combinationally on
// data_valid. data_in, inject_err and inject_pos only matter on the transfer
// edge.
interface ham_encoder_tx_if;
  logic [3:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       inject_err;
  logic [2:0] inject_pos;
  logic       serial_out;
  logic       tx_active;
  logic [6:0] codeword_out;
  logic [7:0] frame_count;

  // Upstream producer / line observer.
  modport master (
    output data_in, data_valid, inject_err, inject_pos,
    input  data_ready, serial_out, tx_active, codeword_out, frame_count
  );

  // The encoder itself.
  modport slave (
    input  data_in, data_valid, inject_err, inject_pos,
    output data_ready, serial_out, tx_active, codeword_out, frame_count
  );
endinterface

// File: rtl/ham_encoder_tx.sv
// Hamming(7,4) encoder with a framed, LSB-first serial transmitter.
// A frame is a start bit (0), codeword bits 0..6, and a stop bit (1), each
// held for BIT_CYCLES clocks. The codeword layout (cw[i] = Hamming position
// i+1) matches the downstream decoder input.
module ham_encoder_tx #(
  parameter int BIT_CYCLES = 1
) (
  input  logic               clock,
  input  logic               reset,
  ham_encoder_tx_if.slave    link,
  output logic [1:0]         fsm_state
);

  localparam int CW = ($clog2(BIT_CYCLES + 1) < 1) ? 1 : $clog2(BIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] cyc_q, cyc_n;
  logic [2:0]    idx_q, idx_n;
  logic [2:0]    idx_inc;
  logic          ready_q, ready_n;
  logic          serial_q, serial_n;
  logic          active_q, active_n;
  logic [6:0]    cw_q, cw_n;
  logic [7:0]    cnt_q, cnt_n;
  logic [6:0]    enc_cw;
  logic [6:0]    inj_cw;
  logic          bit_done;

  // Encode the incoming nibble and apply the optional single-bit flip.
  always_comb begin
    enc_cw    = '0;
    enc_cw[2] = link.data_in[0];
    enc_cw[4] = link.data_in[1];
    enc_cw[5] = link.data_in[2];
    enc_cw[6] = link.data_in[3];
    enc_cw[0] = enc_cw[2] ^ enc_cw[4] ^ enc_cw[6];
    enc_cw[1] = enc_cw[2] ^ enc_cw[5] ^ enc_cw[6];
    enc_cw[3] = enc_cw[4] ^ enc_cw[5] ^ enc_cw[6];
    inj_cw    = enc_cw;
    if (link.inject_err && (link.inject_pos != 3'd7)) begin
      inj_cw[link.inject_pos] = ~enc_cw[link.inject_pos];
    end
  end

  assign bit_done = (cyc_q == LAST_CYC);
  assign idx_inc  = idx_q + 3'd1;

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_n  = state_q;
    cyc_n    = cyc_q;
    idx_n    = idx_q;
    ready_n  = ready_q;
    serial_n = serial_q;
    active_n = active_q;
    cw_n     = cw_q;
    cnt_n    = cnt_q;
    case (state_q)
      IDLE: begin
        // ready comes up on the first edge out of reset and after each frame
        ready_n = 1'b1;
        if (ready_q && link.data_valid) begin
          state_n  = START;
          cw_n     = inj_cw;
          serial_n = 1'b0;
          active_n = 1'b1;
          ready_n  = 1'b0;
          cyc_n    = '0;
        end
      end
      START: begin
        if (bit_done) begin
          state_n  = DATA;
          cyc_n    = '0;
          idx_n    = 3'd0;
          serial_n = cw_q[0];
        end else begin
          cyc_n = cyc_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          cyc_n = '0;
          if (idx_q == 3'd6) begin
            state_n  = STOP;
            serial_n = 1'b1;
          end else begin
            idx_n    = idx_inc;
            serial_n = cw_q[idx_inc];
          end
        end else begin
          cyc_n = cyc_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          state_n  = IDLE;
          cyc_n    = '0;
          active_n = 1'b0;
          ready_n  = 1'b1;
          cnt_n    = cnt_q + 8'd1;
        end else begin
          cyc_n = cyc_q + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cyc_q    <= '0;
      idx_q    <= 3'd0;
      ready_q  <= 1'b0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      cw_q     <= '0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_n;
      cyc_q    <= cyc_n;
      idx_q    <= idx_n;
      ready_q  <= ready_n;
      serial_q <= serial_n;
      active_q <= active_n;
      cw_q     <= cw_n;
      cnt_q    <= cnt_n;
    end
  end

  assign link.data_ready   = ready_q;
  assign link.serial_out   = serial_q;
  assign link.tx_active    = active_q;
  assign link.codeword_out = cw_q;
  assign link.frame_count  = cnt_q;
  assign fsm_state         = state_q;

endmodule
